// File: rtl/combo_lock_param_fsm.sv
// Parametrised combination lock: attempt limit, self-releasing lockout, optional auto-relock,
// runtime re-programming while unlocked. Optional master code via COMBO_LOCK_MASTER_CODE_EN.
module combo_lock_param_fsm #(
    parameter int                   PIN_WIDTH          = 16,
    parameter logic [PIN_WIDTH-1:0] DEFAULT_CODE       = 16'hCACA,
    parameter int                   MAX_ATTEMPTS       = 3,
    parameter int                   LOCKOUT_CYCLES     = 1024,
    parameter int                   AUTO_RELOCK_CYCLES = 0,
`ifdef COMBO_LOCK_MASTER_CODE_EN
    parameter logic [PIN_WIDTH-1:0] MASTER_CODE        = 16'hABBA,
`endif
    parameter int                   ERR_W              = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIN_WIDTH-1:0] pinCode,
    input  logic                 trig,
    input  logic                 lock,
    input  logic                 prog,
    output logic [1:0]           state,
    output logic [ERR_W-1:0]     errCount,
    output logic                 unlocked,
    output logic                 alarm,
    output logic                 codeChanged
);

    typedef enum logic [1:0] {
        S_LOCKED   = 2'b00,
        S_UNLOCKED = 2'b01,
        S_LOCKOUT  = 2'b10,
        S_BAD      = 2'b11
    } state_t;

    localparam int LT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int AR_W = (AUTO_RELOCK_CYCLES > 1) ? $clog2(AUTO_RELOCK_CYCLES) : 1;
    localparam logic [LT_W-1:0]  LT_LOAD = LT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [AR_W-1:0]  AR_LOAD = (AUTO_RELOCK_CYCLES > 0) ? AR_W'(AUTO_RELOCK_CYCLES - 1) : '0;
    localparam bit               AR_EN   = (AUTO_RELOCK_CYCLES > 0);
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(MAX_ATTEMPTS);
    localparam logic [ERR_W-1:0] ERR_LIM = ERR_W'(MAX_ATTEMPTS - 1);

    state_t               state_q, state_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [PIN_WIDTH-1:0] code_q, code_d;
    logic [LT_W-1:0]      lt_q, lt_d;
    logic [AR_W-1:0]      ar_q, ar_d;
    logic                 trig_q;
    logic                 unlocked_d, alarm_d, cc_d;
    logic                 ev, master_hit;

    assign ev = trig & ~trig_q;

`ifdef COMBO_LOCK_MASTER_CODE_EN
    assign master_hit = (pinCode == MASTER_CODE);
`else
    assign master_hit = 1'b0;
`endif

    // state register; outputs are registered alongside so they line up with state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOCKED;
            err_q       <= '0;
            code_q      <= DEFAULT_CODE;
            lt_q        <= '0;
            ar_q        <= '0;
            trig_q      <= 1'b0;
            unlocked    <= 1'b0;
            alarm       <= 1'b0;
            codeChanged <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            code_q      <= code_d;
            lt_q        <= lt_d;
            ar_q        <= ar_d;
            trig_q      <= trig;
            unlocked    <= unlocked_d;
            alarm       <= alarm_d;
            codeChanged <= cc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        code_d  = code_q;
        lt_d    = lt_q;
        ar_d    = ar_q;
        case (state_q)
            S_LOCKED: begin
                if (ev) begin
                    if (pinCode == code_q || master_hit) begin
                        state_d = S_UNLOCKED;
                        err_d   = '0;
                        ar_d    = AR_LOAD;
                    end else if (err_q < ERR_LIM) begin
                        err_d = err_q + ERR_W'(1);
                    end else begin
                        state_d = S_LOCKOUT;
                        err_d   = ERR_MAX;
                        lt_d    = LT_LOAD;
                    end
                end
            end
            S_UNLOCKED: begin
                // lock wins over a same-cycle event, which is dropped
                if (lock) begin
                    state_d = S_LOCKED;
                end else if (ev) begin
                    if (prog) code_d = pinCode;
                    ar_d = AR_LOAD;
                end else if (AR_EN) begin
                    if (ar_q == '0) state_d = S_LOCKED;
                    else            ar_d = ar_q - AR_W'(1);
                end
            end
            S_LOCKOUT: begin
                if (ev && master_hit) begin
                    state_d = S_LOCKED;
                    err_d   = '0;
                    lt_d    = '0;
                end else if (lt_q == '0) begin
                    state_d = S_LOCKED;
                    err_d   = '0;
                end else begin
                    lt_d = lt_q - LT_W'(1);
                end
            end
            default: begin
                state_d = S_LOCKED;
                err_d   = '0;
            end
        endcase
    end

    always_comb begin
        unlocked_d = (state_d == S_UNLOCKED);
        alarm_d    = (state_d == S_LOCKOUT) && (state_q != S_LOCKOUT);
        cc_d       = (state_q == S_UNLOCKED) && !lock && ev && prog;
    end

    assign state    = state_q;
    assign errCount = err_q;

endmodule

// File: tb/tb_combo_lock_param_fsm.sv
// Bench for combo_lock_param_fsm: two instances (auto-relock off / 5 cycles) checked every
// cycle against a behavioural model through a scoreboard, plus directed and random stimulus.
module tb_combo_lock_param_fsm;

    localparam int LO  = 8;
    localparam int MAX = 3;
    localparam logic [15:0] DEF = 16'hCACA;
    localparam logic [15:0] MC  = 16'hABBA;
`ifdef COMBO_LOCK_MASTER_CODE_EN
    localparam bit MASTER = 1'b1;
`else
    localparam bit MASTER = 1'b0;
`endif

    logic        clk, rst, trig, lock, prog;
    logic [15:0] pinCode;
    logic [1:0]  state0, state1, err0, err1;
    logic        unl0, unl1, alarm0, alarm1, cc0, cc1;

    int tests = 0;
    int fails = 0;

    combo_lock_param_fsm #(.LOCKOUT_CYCLES(LO), .AUTO_RELOCK_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .pinCode(pinCode), .trig(trig), .lock(lock), .prog(prog),
        .state(state0), .errCount(err0), .unlocked(unl0), .alarm(alarm0), .codeChanged(cc0));

    combo_lock_param_fsm #(.LOCKOUT_CYCLES(LO), .AUTO_RELOCK_CYCLES(5)) dut1 (
        .clk(clk), .rst(rst), .pinCode(pinCode), .trig(trig), .lock(lock), .prog(prog),
        .state(state1), .errCount(err1), .unlocked(unl1), .alarm(alarm1), .codeChanged(cc1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: 0 locked, 1 unlocked, 2 lockout; counters hold cycles remaining
    typedef struct {
        int          st;
        int          err;
        logic [15:0] code;
        int          lo_left;
        int          ar_left;
        bit          ptrig;
        bit          alarm;
        bit          cc;
    } model_t;

    typedef struct {
        int st;
        int err;
        bit alarm;
        bit cc;
    } exp_t;

    model_t m0, m1;
    exp_t   q0[$], q1[$];
    exp_t   e;

    function automatic model_t step(model_t m, bit r, logic [15:0] pin, bit t, bit l, bit p, int ar);
        bit ev;
        if (r) begin
            m.st = 0; m.err = 0; m.code = DEF; m.lo_left = 0; m.ar_left = 0;
            m.ptrig = 0; m.alarm = 0; m.cc = 0;
            return m;
        end
        ev = t && !m.ptrig;
        m.ptrig = t;
        m.alarm = 0;
        m.cc = 0;
        case (m.st)
            0: if (ev) begin
                if (pin == m.code || (MASTER && pin == MC)) begin
                    m.st = 1; m.err = 0; m.ar_left = ar;
                end else if (m.err + 1 >= MAX) begin
                    m.st = 2; m.err = MAX; m.lo_left = LO; m.alarm = 1;
                end else begin
                    m.err++;
                end
            end
            1: if (l) begin
                m.st = 0;
            end else if (ev) begin
                if (p) begin m.code = pin; m.cc = 1; end
                m.ar_left = ar;
            end else if (ar > 0) begin
                m.ar_left--;
                if (m.ar_left == 0) m.st = 0;
            end
            default: if (ev && MASTER && pin == MC) begin
                m.st = 0; m.err = 0;
            end else begin
                m.lo_left--;
                if (m.lo_left == 0) begin m.st = 0; m.err = 0; end
            end
        endcase
        return m;
    endfunction

    function automatic exp_t exp_of(model_t m);
        exp_t x;
        x.st = m.st; x.err = m.err; x.alarm = m.alarm; x.cc = m.cc;
        return x;
    endfunction

    always @(posedge clk) begin
        m0 = step(m0, rst, pinCode, trig, lock, prog, 0);
        m1 = step(m1, rst, pinCode, trig, lock, prog, 5);
        q0.push_back(exp_of(m0));
        q1.push_back(exp_of(m1));
    end

    task automatic compare(input string nm, input exp_t x, input logic [1:0] st,
                           input logic [1:0] er, input logic un, input logic al, input logic cc);
        tests++;
        if (st !== 2'(x.st) || er !== 2'(x.err) || un !== (x.st == 1) ||
            al !== x.alarm || cc !== x.cc) begin
            fails++;
            $display("FAIL %s t=%0t: got st=%0d err=%0d unl=%0b alarm=%0b cc=%0b, want st=%0d err=%0d unl=%0b alarm=%0b cc=%0b",
                     nm, $time, st, er, un, al, cc, x.st, x.err, (x.st == 1), x.alarm, x.cc);
        end
    endtask

    // monitor: outputs are valid every cycle, so pop one expectation per cycle per instance
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e = q0.pop_front();
            compare("dut0", e, state0, err0, unl0, alarm0, cc0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            compare("dut1", e, state1, err1, unl1, alarm1, cc1);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] pin, input bit p);
        pinCode = pin; prog = p; trig = 1'b1;
        tick();
        trig = 1'b0; prog = 1'b0;
        tick();
    endtask

    initial begin
        int r;
        rst = 1'b1; trig = 1'b0; lock = 1'b0; prog = 1'b0; pinCode = '0;
        tick(); tick();
        chk("reset_state", int'(state0), 0);
        rst = 1'b0;
        tick();

        // correct code, trig held for 10 cycles -> single event
        pinCode = DEF; trig = 1'b1;
        tick();
        chk("unlock_state", int'(state0), 1);
        chk("unlock_led", int'(unl0), 1);
        repeat (10) tick();
        trig = 1'b0;
        tick();

        // reprogram, relock, old code rejected, new code accepted
        pulse(16'hFACE, 1'b1);
        lock = 1'b1; tick(); lock = 1'b0;
        chk("relock_state", int'(state0), 0);
        pulse(DEF, 1'b0);
        chk("old_code_err", int'(err0), 1);
        pulse(16'hFACE, 1'b0);
        chk("new_code_state", int'(state0), 1);

        // three wrong entries -> lockout, correct code ignored, 8-cycle dwell
        lock = 1'b1; tick(); lock = 1'b0;
        pulse(16'hDADA, 1'b0);
        pulse(16'hDADA, 1'b0);
        pinCode = 16'hDADA; trig = 1'b1;
        tick();
        chk("lockout_state", int'(state0), 2);
        chk("lockout_alarm", int'(alarm0), 1);
        trig = 1'b0;
        tick();
        chk("alarm_one_cycle", int'(alarm0), 0);
        pulse(16'hFACE, 1'b0);
        repeat (4) tick();
        chk("lockout_dwell", int'(state0), 2);
        tick();
        chk("lockout_exit", int'(state0), 0);
        chk("lockout_exit_err", int'(err0), 0);

        // lock and prog-trig in the same cycle: lock wins, code kept
        pulse(16'hFACE, 1'b0);
        pinCode = 16'h1234; prog = 1'b1; trig = 1'b1; lock = 1'b1;
        tick();
        trig = 1'b0; prog = 1'b0; lock = 1'b0;
        tick();
        pulse(16'h1234, 1'b0);
        pulse(16'hFACE, 1'b0);

        // reset mid-lockout restores default code
        lock = 1'b1; tick(); lock = 1'b0;
        repeat (3) pulse(16'hDADA, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_lockout", int'(state0), 0);
        pulse(DEF, 1'b0);
        chk("default_code_back", int'(state0), 1);
        repeat (8) tick();

`ifdef COMBO_LOCK_MASTER_CODE_EN
        lock = 1'b1; tick(); lock = 1'b0;
        repeat (3) pulse(16'hDADA, 1'b0);
        pinCode = MC; trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("master_exit", int'(state0), 0);
        chk("master_exit_err", int'(err0), 0);
        tick();
`endif

        // random phase
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            trig = ($urandom_range(0, 2) == 0);
            lock = ($urandom_range(0, 11) == 0);
            prog = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 4);
            case (r)
                0: pinCode = m0.code;
                1: pinCode = DEF;
                2: pinCode = 16'hDADA;
                3: pinCode = MC;
                default: pinCode = 16'($urandom);
            endcase
            tick();
        end
        rst = 1'b0; trig = 1'b0; lock = 1'b0; prog = 1'b0;
        tick(); tick();
        chk("scoreboard_drained", int'(q0.size() <= 1 && q1.size() <= 1), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
